// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage fetch sequencer, one outstanding imem request, DEPTH-entry buffer toward decode.
// Define FETCH_CTRL_BYPASS_EN to hand a response to decode in its arrival cycle when the buffer is empty.
module fetch_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic [31:0] pc_i,
  output logic        pc_en_o,
  output logic        tk_brnch_o,
  output logic [31:0] target_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  input  logic        id_ready_i
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pending_pc_q, pending_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   ipc_q [DEPTH];
  logic          push, bypass, buf_push, buf_pop;

  assign imem_addr_o = pc_i;

  always_comb begin
    state_d      = state_q;
    pending_pc_d = pending_pc_q;
    imem_req_o   = 1'b0;
    push         = 1'b0;
    tk_brnch_o   = redirect_i && state_q != IDLE;
    target_o     = tk_brnch_o ? redirect_target_i : '0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req_o = !redirect_i && count_q < FULL;
        if (imem_req_o && imem_gnt_i) begin
          pending_pc_d = pc_i;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        push    = imem_rvalid_i && !redirect_i;
        state_d = imem_rvalid_i ? REQ : redirect_i ? DRAIN : WAIT;
      end
      default: state_d = imem_rvalid_i ? REQ : DRAIN;
    endcase
    pc_en_o = tk_brnch_o || (imem_req_o && imem_gnt_i);
  end

`ifdef FETCH_CTRL_BYPASS_EN
  assign bypass = push && count_q == '0;
`else
  assign bypass = 1'b0;
`endif

  assign id_valid_o = count_q != '0 || bypass;
  assign id_instr_o = bypass ? imem_rdata_i : instr_q[rd_ptr_q];
  assign id_pc_o    = bypass ? pending_pc_q : ipc_q[rd_ptr_q];
  // A bypassed word that decode takes right away never occupies a slot.
  assign buf_push   = push && !(bypass && id_ready_i);
  assign buf_pop    = id_ready_i && count_q != '0 && !tk_brnch_o;

  always_comb begin
    wr_ptr_d = buf_push ? (wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = buf_pop ? (rd_ptr_q == LAST ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = tk_brnch_o ? '0 : count_q + CW'(buf_push) - CW'(buf_pop);
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q      <= IDLE;
      pending_pc_q <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      instr_q      <= '{default: '0};
      ipc_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      pending_pc_q <= pending_pc_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      if (buf_push) begin
        instr_q[wr_ptr_q] <= imem_rdata_i;
        ipc_q[wr_ptr_q]   <= pending_pc_q;
      end
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: models the PC register and instruction memory around fetch_ctrl and
// scoreboards every word decode accepts against the responses the memory returned.
module tb_fetch_ctrl;
  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic [31:0] pc_i;
  logic        pc_en_o, tk_brnch_o;
  logic [31:0] target_o;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        id_valid_o;
  logic [31:0] id_instr_o, id_pc_o;
  logic        id_ready_i;

  fetch_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .pc_i(pc_i), .pc_en_o(pc_en_o),
    .tk_brnch_o(tk_brnch_o), .target_o(target_o), .redirect_i(redirect_i),
    .redirect_target_i(redirect_target_i), .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i), .id_valid_o(id_valid_o), .id_instr_o(id_instr_o),
    .id_pc_o(id_pc_o), .id_ready_i(id_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int pops, gcount, rem;
  logic busy = 1'b0, stale = 1'b0, grant_s, stale_set;
  logic [31:0] cur_addr, g_addr, pc_n;
  logic [63:0] exp_q[$];
  logic [63:0] e;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Environment: sample on the falling edge, apply PC/memory updates just after the rising edge.
  always begin
    @(negedge clk_i);
    grant_s   = 1'b0;
    stale_set = 1'b0;
    if (arstn_i) begin
      if (imem_rvalid_i && !stale && !redirect_i) exp_q.push_back({cur_addr, imem_rdata_i});
      if (id_valid_o && id_ready_i) begin
        pops++;
        check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("id_pc", id_pc_o, e[63:32]);
          check("id_instr", id_instr_o, e[31:0]);
        end
      end
      if (redirect_i) exp_q.delete();
      pc_n      = pc_en_o ? (tk_brnch_o ? target_o : pc_i + 32'd4) : pc_i;
      grant_s   = imem_req_o && imem_gnt_i;
      g_addr    = imem_addr_o;
      stale_set = redirect_i && busy && !imem_rvalid_i;
    end
    @(posedge clk_i);
    #1;
    if (!arstn_i) begin
      pc_i = '0;
      imem_rvalid_i = 1'b0;
      busy = 1'b0;
      stale = 1'b0;
      pops = 0;
      gcount = 0;
      exp_q.delete();
    end else begin
      if (imem_rvalid_i) begin
        imem_rvalid_i = 1'b0;
        busy = 1'b0;
        stale = 1'b0;
      end else if (busy) begin
        rem--;
        if (rem == 0) begin imem_rvalid_i = 1'b1; imem_rdata_i = instr_of(cur_addr); end
      end
      if (grant_s) begin
        gcount++;
        busy = 1'b1;
        cur_addr = g_addr;
        rem = lat - 1;
        if (rem == 0) begin imem_rvalid_i = 1'b1; imem_rdata_i = instr_of(cur_addr); end
      end
      if (stale_set) stale = 1'b1;
      pc_i = pc_n;
    end
  end

  always @(negedge clk_i) if (arstn_i) assert (dut.count_q <= DEPTH);

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk_i); #2; end
  endtask

  task automatic wait_grant(output logic [31:0] a, output int w, input int bound);
    for (w = 0; w < bound; w++) begin
      if (imem_req_o && imem_gnt_i) break;
      cyc(1);
    end
    check("grant_seen", 32'(imem_req_o && imem_gnt_i), 32'd1);
    a = imem_addr_o;
  endtask

  task automatic wait_valid(input int bound);
    for (int i = 0; i < bound && !id_valid_o; i++) cyc(1);
    check("valid_seen", 32'(id_valid_o), 32'd1);
  endtask

  task automatic do_reset(input int l, input logic rdy);
    arstn_i = 1'b0;
    lat = l;
    id_ready_i = rdy;
    redirect_i = 1'b0;
    cyc(3);
    arstn_i = 1'b1;
    #1;
  endtask

  logic [31:0] a;
  int w;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    arstn_i = 1'b0; redirect_i = 1'b0; redirect_target_i = '0;
    id_ready_i = 1'b1; imem_gnt_i = 1'b1;
    // Reset state and back-to-back fetch with single-cycle memory.
    cyc(3);
    check("rst_req", 32'(imem_req_o), 0);
    check("rst_pc_en", 32'(pc_en_o), 0);
    check("rst_tk", 32'(tk_brnch_o), 0);
    check("rst_valid", 32'(id_valid_o), 0);
    check("rst_target", target_o, 0);
    check("rst_instr", id_instr_o, 0);
    check("rst_idpc", id_pc_o, 0);
    arstn_i = 1'b1;
    #1;
    check("t1_idle_req", 32'(imem_req_o), 0);
    wait_grant(a, w, 5);
    check("t1_a0", a, 32'h0);
    check("t1_w0", 32'(w), 1);
    for (int k = 1; k < 3; k++) begin
      cyc(1);
      wait_grant(a, w, 5);
      check("t1_addr", a, 32'(4 * k));
      check("t1_gap", 32'(w), 1);
    end
    cyc(3);
    check("t1_pops", 32'(pops), 3);

    // Decode stalled: buffer fills, PC freezes, one pop frees one fetch.
    do_reset(1, 1'b0);
    cyc(10);
    check("t2_grants", 32'(gcount), 2);
    check("t2_req", 32'(imem_req_o), 0);
    check("t2_pc", pc_i, 32'h8);
    check("t2_head", id_pc_o, 32'h0);
    id_ready_i = 1'b1;
    cyc(1);
    id_ready_i = 1'b0;
    #1;
    check("t2_req1", 32'(imem_req_o), 1);
    check("t2_addr1", imem_addr_o, 32'h8);
    check("t2_head1", id_pc_o, 32'h4);
    cyc(2);
    check("t2_refull", 32'(imem_req_o), 0);
    check("t2_pc2", pc_i, 32'hC);

    // Redirect while waiting on a slow response: drain it, then fetch the target.
    do_reset(4, 1'b1);
    wait_grant(a, w, 5);
    cyc(1);
    redirect_i = 1'b1; redirect_target_i = 32'h100;
    #1;
    check("t3_tk", 32'(tk_brnch_o), 1);
    check("t3_target", target_o, 32'h100);
    check("t3_pc_en", 32'(pc_en_o), 1);
    check("t3_req", 32'(imem_req_o), 0);
    cyc(1);
    redirect_i = 1'b0;
    #1;
    check("t3_tk0", 32'(tk_brnch_o), 0);
    check("t3_target0", target_o, 0);
    check("t3_drain_req", 32'(imem_req_o), 0);
    check("t3_pc", pc_i, 32'h100);
    cyc(2);
    check("t3_drop_valid", 32'(id_valid_o), 0);
    check("t3_drop_req", 32'(imem_req_o), 0);
    cyc(1);
    check("t3_req_t", 32'(imem_req_o), 1);
    check("t3_addr_t", imem_addr_o, 32'h100);
    wait_valid(12);
    check("t3_first", id_pc_o, 32'h100);

    // Redirect in the same cycle as the response.
    do_reset(2, 1'b1);
    wait_grant(a, w, 5);
    cyc(2);
    redirect_i = 1'b1; redirect_target_i = 32'h200;
    #1;
    check("t4_tk", 32'(tk_brnch_o), 1);
    check("t4_req", 32'(imem_req_o), 0);
    check("t4_valid", 32'(id_valid_o), 0);
    cyc(1);
    redirect_i = 1'b0;
    #1;
    check("t4_pc", pc_i, 32'h200);
    check("t4_req1", 32'(imem_req_o), 1);
    check("t4_addr", imem_addr_o, 32'h200);
    check("t4_valid1", 32'(id_valid_o), 0);
    wait_valid(8);
    check("t4_first", id_pc_o, 32'h200);

    // Full buffer flushed by a redirect.
    do_reset(1, 1'b0);
    cyc(10);
    check("t5_full_valid", 32'(id_valid_o), 1);
    check("t5_full_req", 32'(imem_req_o), 0);
    redirect_i = 1'b1; redirect_target_i = 32'h40;
    #1;
    check("t5_tk", 32'(tk_brnch_o), 1);
    check("t5_pc_en", 32'(pc_en_o), 1);
    cyc(1);
    redirect_i = 1'b0;
    #1;
    check("t5_tk0", 32'(tk_brnch_o), 0);
    check("t5_flushed", 32'(id_valid_o), 0);
    check("t5_req", 32'(imem_req_o), 1);
    check("t5_addr", imem_addr_o, 32'h40);
    id_ready_i = 1'b1;
    wait_valid(6);
    check("t5_first", id_pc_o, 32'h40);

    // Response-to-decode latency on an empty buffer.
    do_reset(1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      wait_grant(a, w, 4);
      if (a == 32'h14) break;
      cyc(1);
    end
    check("t6_addr", a, 32'h14);
    cyc(1);
`ifdef FETCH_CTRL_BYPASS_EN
    check("t6_byp_valid", 32'(id_valid_o), 1);
    check("t6_byp_pc", id_pc_o, 32'h14);
    check("t6_byp_instr", id_instr_o, instr_of(32'h14));
    cyc(1);
    check("t6_byp_empty", 32'(id_valid_o), 0);
`else
    check("t6_nobyp_valid", 32'(id_valid_o), 0);
    cyc(1);
    check("t6_valid", 32'(id_valid_o), 1);
    check("t6_pc", id_pc_o, 32'h14);
    check("t6_instr", id_instr_o, instr_of(32'h14));
`endif
    cyc(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
